// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline latch: state encoding and default widths.
// Latency: none (package only).
// Backpressure: none (package only).
package pipe_pkg;

  // State encoding doubles as the occupancy count (0, 1 or 2 held entries).
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

endpackage

// File: rtl/pipe_reg.sv
// Parametrised-width register with load enable and synchronous clear.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; the owner decides when to load via en.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load; otherwise hold.
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Generic inter-stage latch carrying ctrl+data under valid/ready, with flush-to-bubble and optional skid entry.
// Latency: 1 cycle from input transfer to out_*; 1 entry/cycle while downstream is ready.
// Backpressure: SKID=1 gives a registered in_ready (absorbs one extra entry); SKID=0 passes out_ready through combinationally.
module pipe_stage_latch #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);
  import pipe_pkg::*;

  localparam int W = CTRL_W + DATA_W;

  logic [1:0]   state;
  logic         inXfer;
  logic         outXfer;
  logic         loadMain;
  logic         loadSkid;
  logic [W-1:0] inEntry;
  logic [W-1:0] mainD;
  logic [W-1:0] mainQ;
  logic [W-1:0] skidQ;

  assign inEntry   = {in_ctrl, in_data};
  assign out_valid = (state != ST_EMPTY);
  assign occ       = state;

  // In skid mode readiness comes only from registered state; otherwise a full latch frees up when downstream takes.
  always_comb begin
    in_ready = 1'b0;
    if (!clr) begin
      if (SKID) in_ready = (state != ST_SKID);
      else      in_ready = (state == ST_EMPTY) || out_ready;
    end
  end

  assign inXfer  = in_valid & in_ready;
  assign outXfer = out_valid & out_ready;

  // Main entry loads from upstream, or from the skid entry when draining SKID; a flush blocks all loads.
  always_comb begin
    loadMain = 1'b0;
    loadSkid = 1'b0;
    mainD    = inEntry;
    if (!flush) begin
      case (state)
        ST_EMPTY: loadMain = inXfer;
        ST_FULL: begin
          loadMain = inXfer & out_ready;
          loadSkid = SKID & inXfer & ~out_ready;
        end
        ST_SKID: begin
          loadMain = outXfer;
          mainD    = skidQ;
        end
        default: ;
      endcase
    end
  end

  // Occupancy FSM: clr beats flush beats normal transfers.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (inXfer) state <= ST_FULL;
        ST_FULL: begin
          if (outXfer && !inXfer)                      state <= ST_EMPTY;
          else if (SKID && inXfer && !out_ready)       state <= ST_SKID;
        end
        ST_SKID:  if (outXfer) state <= ST_FULL;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  pipe_reg #(.W(W)) u_main (
    .clk (clk),
    .clr (clr),
    .en  (loadMain),
    .d   (mainD),
    .q   (mainQ)
  );

  generate
    if (SKID) begin : g_skid
      pipe_reg #(.W(W)) u_skid (
        .clk (clk),
        .clr (clr),
        .en  (loadSkid),
        .d   (inEntry),
        .q   (skidQ)
      );
    end else begin : g_noskid
      assign skidQ = '0;
    end
  endgenerate

  // Control is forced to zero on bubbles; data keeps its last value.
  assign out_ctrl = mainQ[W-1 -: CTRL_W] & {CTRL_W{out_valid}};
  assign out_data = mainQ[DATA_W-1:0];

endmodule
